// File: rtl/cart_pkg.sv
// Shared constants and types for the MBC1 cartridge controller.
package cart_pkg;

    // CPU address windows
    localparam logic [15:0] ROM0_LIMIT   = 16'h3FFF;
    localparam logic [15:0] ROMN_BASE    = 16'h4000;
    localparam logic [15:0] ROMN_LIMIT   = 16'h7FFF;
    localparam logic [15:0] EXTRAM_BASE  = 16'hA000;
    localparam logic [15:0] EXTRAM_LIMIT = 16'hBFFF;

    // Register write windows (the RAM-enable window starts at 0000)
    localparam logic [15:0] REG_BANKLO_BASE = 16'h2000;
    localparam logic [15:0] REG_BANKHI_BASE = 16'h4000;
    localparam logic [15:0] REG_MODE_BASE   = 16'h6000;

    localparam int unsigned ROM_BANK_BYTES = 16384;
    localparam int unsigned RAM_BANK_BYTES = 8192;
    localparam int unsigned ROM_OFS_W      = $clog2(ROM_BANK_BYTES);
    localparam int unsigned RAM_OFS_W      = $clog2(RAM_BANK_BYTES);

    typedef enum logic [1:0] {
        RegRamEn,
        RegBankLo,
        RegBankHi,
        RegMode
    } reg_sel_e;

    typedef struct packed {
        logic       ram_en;
        logic [4:0] bank_lo;
        logic [1:0] bank_hi;
        logic       mode;
    } mbc_regs_t;

endpackage

// File: rtl/cart_mbc1_if.sv
// CPU-side bus and storage-side outputs of the MBC1 controller.
interface cart_mbc1_if;
    logic [15:0] addr;
    logic [7:0]  data_w;
    logic        write_enable;
    logic        save_ack;
    logic [20:0] rom_addr;
    logic        rom_cs;
    logic [14:0] ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_dirty;
    logic [4:0]  bank_lo;

    modport master (
        output addr, data_w, write_enable, save_ack,
        input  rom_addr, rom_cs, ram_addr, ram_cs, ram_we, ram_dirty, bank_lo
    );

    modport slave (
        input  addr, data_w, write_enable, save_ack,
        output rom_addr, rom_cs, ram_addr, ram_cs, ram_we, ram_dirty, bank_lo
    );
endinterface

// File: rtl/cart_mbc_decode.sv
// Combinational CPU address window decode for the MBC1 controller.
module cart_mbc_decode
    import cart_pkg::*;
(
    input  logic [15:0] addr,
    output logic        rom0_win,
    output logic        romn_win,
    output logic        ram_win,
    output reg_sel_e    reg_sel
);

    // Window flags and register select; reg_sel is only meaningful inside the ROM window
    always_comb begin
        rom0_win = addr <= ROM0_LIMIT;
        romn_win = (addr >= ROMN_BASE) && (addr <= ROMN_LIMIT);
        ram_win  = (addr >= EXTRAM_BASE) && (addr <= EXTRAM_LIMIT);
        if (addr >= REG_MODE_BASE) begin
            reg_sel = RegMode;
        end else if (addr >= REG_BANKHI_BASE) begin
            reg_sel = RegBankHi;
        end else if (addr >= REG_BANKLO_BASE) begin
            reg_sel = RegBankLo;
        end else begin
            reg_sel = RegRamEn;
        end
    end

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 bank controller: bank registers, registered address translation, EXTRAM dirty flag.
// Optional MBC1M (multicart) wiring is selected with `define MBC1_MULTICART_EN.
module cart_mbc1
    import cart_pkg::*;
#(
    parameter int unsigned ROM_BANKS = 64,
    parameter int unsigned RAM_BANKS = 4
) (
    input logic        clk,
    input logic        reset,
    cart_mbc1_if.slave bus
);

    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
    localparam bit         HAS_RAM  = (RAM_BANKS != 0);

    logic      rom0_win, romn_win, ram_win, rom_win;
    reg_sel_e  reg_sel;

    logic      we_q;
    logic      commit;
    mbc_regs_t regs_q, regs_d;
    logic [4:0] bank_lo_wr;

    logic [6:0]  bank_n, bank_0, rom_bank;
    logic [1:0]  ram_bank;
    logic [20:0] rom_addr_d, rom_addr_q;
    logic [14:0] ram_addr_d, ram_addr_q;
    logic        ram_ok;
    logic        rom_cs_q, ram_cs_q, ram_we_q;
    logic        dirty_d, dirty_q;

    cart_mbc_decode u_decode (
        .addr     (bus.addr),
        .rom0_win (rom0_win),
        .romn_win (romn_win),
        .ram_win  (ram_win),
        .reg_sel  (reg_sel)
    );

    assign rom_win = rom0_win || romn_win;
    // Rising edge of the strobe: a held strobe commits once
    assign commit  = bus.write_enable && !we_q;
    assign ram_ok  = ram_win && regs_q.ram_en && HAS_RAM;

`ifdef MBC1_MULTICART_EN
    logic [3:0] unused_data;
    assign unused_data = bus.data_w[7:4];
`else
    logic [2:0] unused_data;
    assign unused_data = bus.data_w[7:5];
`endif

    // Bank-low write value; only an all-zero field maps to 1, so 20h/40h/60h remap naturally
    always_comb begin
`ifdef MBC1_MULTICART_EN
        bank_lo_wr = {1'b0, bus.data_w[3:0]};
`else
        bank_lo_wr = bus.data_w[4:0];
`endif
        if (bank_lo_wr == 5'd0) begin
            bank_lo_wr = 5'd1;
        end
    end

    // Next-state of the bank registers on a committed write into 0000-7FFF
    always_comb begin
        regs_d = regs_q;
        if (commit && rom_win) begin
            unique case (reg_sel)
                RegRamEn:  regs_d.ram_en  = (bus.data_w[3:0] == 4'hA);
                RegBankLo: regs_d.bank_lo = bank_lo_wr;
                RegBankHi: regs_d.bank_hi = bus.data_w[1:0];
                RegMode:   regs_d.mode    = bus.data_w[0];
            endcase
        end
    end

    // Physical address translation from current registers and CPU address
    always_comb begin
`ifdef MBC1_MULTICART_EN
        bank_n = {1'b0, regs_q.bank_hi, regs_q.bank_lo[3:0]};
        bank_0 = {1'b0, regs_q.bank_hi, 4'b0};
`else
        bank_n = {regs_q.bank_hi, regs_q.bank_lo};
        bank_0 = {regs_q.bank_hi, 5'b0};
`endif
        rom_bank   = rom0_win ? (regs_q.mode ? bank_0 : 7'd0) : bank_n;
        rom_bank   = rom_bank & ROM_MASK;
        rom_addr_d = {rom_bank, bus.addr[ROM_OFS_W-1:0]};
        ram_bank   = (RAM_BANKS == 4 && regs_q.mode) ? regs_q.bank_hi : 2'b00;
        ram_addr_d = {ram_bank, bus.addr[RAM_OFS_W-1:0]};
    end

    // Dirty flag: a committed EXTRAM write takes priority over save_ack
    always_comb begin
        dirty_d = dirty_q;
        if (bus.save_ack) begin
            dirty_d = 1'b0;
        end
        if (commit && ram_ok) begin
            dirty_d = 1'b1;
        end
    end

    // Bank registers, strobe history and dirty flag
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            regs_q  <= '{ram_en: 1'b0, bank_lo: 5'd1, bank_hi: 2'd0, mode: 1'b0};
            dirty_q <= 1'b0;
        end else begin
            we_q    <= bus.write_enable;
            regs_q  <= regs_d;
            dirty_q <= dirty_d;
        end
    end

    // Registered storage-side address and chip selects; addresses hold outside their window
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
        end else begin
            if (rom_win) begin
                rom_addr_q <= rom_addr_d;
            end
            if (ram_win && HAS_RAM) begin
                ram_addr_q <= ram_addr_d;
            end
            rom_cs_q <= rom_win && !bus.write_enable;
            ram_cs_q <= ram_ok;
            ram_we_q <= ram_ok && bus.write_enable;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_cs    = rom_cs_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_dirty = dirty_q;
    assign bus.bank_lo   = regs_q.bank_lo;

endmodule

// File: tb/tb_cart_mbc1.sv
// Table-driven bench for cart_mbc1 with a scoreboard queue of expected output records.
module tb_cart_mbc1;

    typedef struct {
        logic        rst;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        ack;
        logic [20:0] rom_addr;
        logic        rom_cs;
        logic [14:0] ram_addr;
        logic        ram_cs;
        logic        ram_we;
        logic        dirty;
        logic [4:0]  lo;
        int          idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;
    int   vec_n  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    cart_mbc1_if bus ();

    cart_mbc1 #(
        .ROM_BANKS (64),
        .RAM_BANKS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [15:0] a, logic [7:0] d, logic we, logic ack,
                                logic [20:0] ra, logic rcs, logic [14:0] xa, logic xcs,
                                logic xwe, logic dty, logic [4:0] lo);
        vec_t v;
        v.rst = rst; v.addr = a; v.data = d; v.we = we; v.ack = ack;
        v.rom_addr = ra; v.rom_cs = rcs; v.ram_addr = xa; v.ram_cs = xcs;
        v.ram_we = xwe; v.dirty = dty; v.lo = lo; v.idx = 0;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL vec%0d %s: got %0h, want %0h", idx, nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the next edge
    task automatic apply(input vec_t v);
        @(negedge clk);
        v.idx            = vec_n++;
        reset            = v.rst;
        bus.addr         = v.addr;
        bus.data_w       = v.data;
        bus.write_enable = v.we;
        bus.save_ack     = v.ack;
        sb.push_back(v);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rom_addr",  e.idx, 32'(bus.rom_addr),  32'(e.rom_addr));
            chk("rom_cs",    e.idx, 32'(bus.rom_cs),    32'(e.rom_cs));
            chk("ram_addr",  e.idx, 32'(bus.ram_addr),  32'(e.ram_addr));
            chk("ram_cs",    e.idx, 32'(bus.ram_cs),    32'(e.ram_cs));
            chk("ram_we",    e.idx, 32'(bus.ram_we),    32'(e.ram_we));
            chk("ram_dirty", e.idx, 32'(bus.ram_dirty), 32'(e.dirty));
            chk("bank_lo",   e.idx, 32'(bus.bank_lo),   32'(e.lo));
        end
    end

    initial begin
        reset            = 1'b1;
        bus.addr         = 16'h8000;
        bus.data_w       = 8'h00;
        bus.write_enable = 1'b0;
        bus.save_ack     = 1'b0;

        // Reset state
        tbl.push_back(mk(1, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(1, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h0000, 0, 0, 0, 5'h01));
`ifdef MBC1_MULTICART_EN
        tbl.push_back(mk(0, 16'h2000, 8'h10, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h4000, 8'h01, 1, 0, 21'h04000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h04000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h4000, 8'h00, 0, 0, 21'h44000, 1, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h2000, 8'h1F, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h0F));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h0F));
        tbl.push_back(mk(0, 16'h4000, 8'h00, 0, 0, 21'h7C000, 1, 15'h0000, 0, 0, 0, 5'h0F));
`else
        tbl.push_back(mk(0, 16'h4123, 8'h00, 0, 0, 21'h04123, 1, 15'h0000, 0, 0, 0, 5'h01));
        // Zero bank write stores 1
        tbl.push_back(mk(0, 16'h2000, 8'h00, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h2000, 8'h1F, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h1F));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h1F));
        tbl.push_back(mk(0, 16'h4000, 8'h01, 1, 0, 21'h7C000, 0, 15'h0000, 0, 0, 0, 5'h1F));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h7C000, 0, 15'h0000, 0, 0, 0, 5'h1F));
        tbl.push_back(mk(0, 16'h4000, 8'h00, 0, 0, 21'hFC000, 1, 15'h0000, 0, 0, 0, 5'h1F));
        // Held strobe: one commit with the first data
        tbl.push_back(mk(0, 16'h2000, 8'h05, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h05));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(0, 16'h2000, 8'h07, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h05));
        end
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h4000, 8'h00, 0, 0, 21'h94000, 1, 15'h0000, 0, 0, 0, 5'h05));
        // mode=1, bank_hi=2
        tbl.push_back(mk(0, 16'h6000, 8'h01, 1, 0, 21'h96000, 0, 15'h0000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h96000, 0, 15'h0000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h4000, 8'h02, 1, 0, 21'h94000, 0, 15'h0000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h94000, 0, 15'h0000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h0010, 8'h00, 0, 0, 21'h00010, 1, 15'h0000, 0, 0, 0, 5'h05));
        // EXTRAM write while disabled
        tbl.push_back(mk(0, 16'hA000, 8'h55, 1, 0, 21'h00010, 0, 15'h4000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00010, 0, 15'h4000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h0000, 8'h0A, 1, 0, 21'h00000, 0, 15'h4000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h4000, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'hA005, 8'h00, 0, 0, 21'h00000, 0, 15'h4005, 1, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'hA000, 8'h12, 1, 0, 21'h00000, 0, 15'h4000, 1, 1, 1, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h4000, 0, 0, 1, 5'h05));
        // save_ack with a RAM write in the same cycle: set wins
        tbl.push_back(mk(0, 16'hA001, 8'h34, 1, 1, 21'h00000, 0, 15'h4001, 1, 1, 1, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 1, 21'h00000, 0, 15'h4001, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h4001, 0, 0, 0, 5'h05));
        // 0Bh disables RAM again
        tbl.push_back(mk(0, 16'h0000, 8'h0B, 1, 0, 21'h00000, 0, 15'h4001, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h4001, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'hA002, 8'h56, 1, 0, 21'h00000, 0, 15'h4002, 0, 0, 0, 5'h05));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h00000, 0, 15'h4002, 0, 0, 0, 5'h05));
        // 20h has zero low 5 bits -> stored as 1; bank 41h masks to 1
        tbl.push_back(mk(0, 16'h2000, 8'h20, 1, 0, 21'h02000, 0, 15'h4002, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h4002, 0, 0, 0, 5'h01));
        tbl.push_back(mk(0, 16'h4000, 8'h00, 0, 0, 21'h04000, 1, 15'h4002, 0, 0, 0, 5'h01));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Strobe held high across reset release commits exactly once
        apply(mk(1, 16'h2000, 8'h03, 1, 0, 21'h00000, 0, 15'h0000, 0, 0, 0, 5'h01));
        apply(mk(0, 16'h2000, 8'h03, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h03));
        apply(mk(0, 16'h2000, 8'h04, 1, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h03));
        apply(mk(0, 16'h8000, 8'h00, 0, 0, 21'h02000, 0, 15'h0000, 0, 0, 0, 5'h03));
        apply(mk(0, 16'h4000, 8'h00, 0, 0, 21'h0C000, 1, 15'h0000, 0, 0, 0, 5'h03));

        // Bounded drain of the scoreboard
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
